dmem_responder: RTL

Data-memory responder serving the load/store side of the 32-bit MIPS CPU. It accepts one word-addressed request at a time from the CPU's memory interface and holds it for a programmable number of wait cycles. It then commits the store or returns the load word on `readdata` with a one-cycle `ready` pulse. The block is the slave end of the CPU data bus and sits between the CPU and the top-level testbench/system.

---
 rtl/dmem_responder.sv | 94 +++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data-memory slave with programmable wait latency,
// byte-enabled stores and misaligned-access flagging.
module dmem_responder #(
    parameter int n       = 32,
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req,
    input  logic         memwrite,
    input  logic [n-1:0] addr,
    input  logic [n-1:0] writedata,
    input  logic [3:0]   be,
    output logic [n-1:0] readdata,
    output logic         ready,
    output logic         err,
    output logic         busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            wr_q;
    logic [n-1:0]    addr_q, wdata_q;
    logic [3:0]      be_q;
    logic [n-1:0]    readdata_q, readdata_d;
    logic            err_q, err_d;
    logic [n-1:0]    mem_q [DEPTH] = '{default: '0};

    logic            take, acc, acc_wr, acc_mis;
    logic [n-1:0]    acc_addr, acc_wdata;
    logic [3:0]      acc_be;
    logic [AW-1:0]   acc_idx;
    logic            unused_addr;

    // With LATENCY=1 the access happens on the accepting edge, so use the live request fields.
    always_comb begin
        take       = (state_q == IDLE) && req;
        acc        = (take && LATENCY == 1) || (state_q == WAIT && cnt_q == CW'(1));
        acc_wr     = (state_q == IDLE) ? memwrite : wr_q;
        acc_addr   = (state_q == IDLE) ? addr : addr_q;
        acc_wdata  = (state_q == IDLE) ? writedata : wdata_q;
        acc_be     = (state_q == IDLE) ? be : be_q;
        acc_idx    = acc_addr[AW+1:2];
        acc_mis    = acc_addr[1:0] != 2'b00;
        state_d    = take ? (LATENCY == 1 ? RESP : WAIT)
                   : (state_q == WAIT) ? (acc ? RESP : WAIT) : IDLE;
        cnt_d      = take ? CW'(LATENCY - 1) : (state_q == WAIT) ? cnt_q - CW'(1) : cnt_q;
        readdata_d = acc ? ((acc_mis || acc_wr) ? '0 : mem_q[acc_idx]) : readdata_q;
        err_d      = acc ? acc_mis : err_q;
    end

    assign unused_addr = ^{acc_addr[n-1:AW+2]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            readdata_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            readdata_q <= readdata_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && take) begin
            wr_q    <= memwrite;
            addr_q  <= addr;
            wdata_q <= writedata;
            be_q    <= be;
        end
    end

    // The array has no reset; a reset on the access edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!reset && acc && acc_wr && !acc_mis)
            for (int i = 0; i < 4; i++)
                if (acc_be[i])
                    mem_q[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
    end

    assign readdata = readdata_q;
    assign ready    = state_q == RESP;
    assign err      = (state_q == RESP) && err_q;
    assign busy     = state_q != IDLE;
endmodule
